// File: rtl/tt_alvin_pkg.sv
// Shared constants and helpers for the registered 3-input logic cell.
package tt_alvin_pkg;

  // Output-mode encodings carried on ui_in[7:6]
  localparam logic [1:0] MODE_DIRECT = 2'd0;
  localparam logic [1:0] MODE_STICKY = 2'd1;
  localparam logic [1:0] MODE_TOGGLE = 2'd2;
  localparam logic [1:0] MODE_HOLD   = 2'd3;

  // ui_in field layout: channel c occupies bits [3c+2:3c] as {C,B,A}
  localparam int unsigned CH_BITS      = 3;
  localparam int unsigned BIT_A        = 0;
  localparam int unsigned BIT_B        = 1;
  localparam int unsigned BIT_C        = 2;
  localparam int unsigned UI_MODE_LSB  = 6;
  localparam int unsigned UI_MODE_MSB  = 7;

  // uio layout: bit 0 is the clear input, the rest drive the counter
  localparam int unsigned UIO_CLR_BIT  = 0;
  localparam logic [7:0]  UIO_OE_VAL   = 8'b1111_1110;

  // uo_out fixed positions
  localparam int unsigned UO_RISE_LSB  = 4;
  localparam int unsigned UO_OVF_BIT   = 6;

  // Cell function: x = (A & B) | ~C
  function automatic logic gate_f(input logic a, input logic b, input logic c);
    return (a & b) | ~c;
  endfunction

endpackage

// File: rtl/tt_um_alvin_asmar_logic_seq_if.sv
// Pin bundle for the TinyTapeout user-module port set.
interface tt_um_alvin_asmar_logic_seq_if;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uo_out;
  logic [7:0] uio_in;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  // Driver side (harness / pad ring)
  modport master (
    output ena, ui_in, uio_in,
    input  uo_out, uio_out, uio_oe
  );

  // Design side
  modport slave (
    input  ena, ui_in, uio_in,
    output uo_out, uio_out, uio_oe
  );
endinterface

// File: rtl/tt_alvin_sync_deb.sv
// One-bit synchroniser followed by an optional stability filter.
module tt_alvin_sync_deb #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned DEB_CYCLES  = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_in,
  output logic q_out
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_bit;

  // Metastability chain; newest sample enters at bit 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d_in};
    end
  end

  assign sync_bit = sync_q[SYNC_STAGES-1];

  generate
    if (DEB_CYCLES == 0) begin : g_bypass
      assign q_out = sync_bit;
    end else begin : g_deb
      localparam int unsigned CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

      logic [CW-1:0] cnt_q;
      logic          deb_q;

      // Accept a new level only after DEB_CYCLES consecutive disagreeing samples
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          cnt_q <= '0;
          deb_q <= 1'b0;
        end else if (sync_bit == deb_q) begin
          cnt_q <= '0;
        end else if (cnt_q == CW'(DEB_CYCLES - 1)) begin
          deb_q <= sync_bit;
          cnt_q <= '0;
        end else begin
          cnt_q <= cnt_q + CW'(1);
        end
      end

      assign q_out = deb_q;
    end
  endgenerate

endmodule

// File: rtl/tt_um_alvin_asmar_logic_seq.sv
// Registered, multi-channel (A&B)|~C cell with output modes and event counter.
module tt_um_alvin_asmar_logic_seq
  import tt_alvin_pkg::*;
#(
  parameter int unsigned NCH         = 2,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned DEB_CYCLES  = 4,
  parameter int unsigned CNT_W       = 7,
  parameter bit          CNT_SAT     = 1'b1
) (
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe,
  input  logic       ena,
  input  logic       clk,
  input  logic       rst_n
);

  localparam int unsigned NB = CH_BITS * NCH;
  localparam int unsigned SW = CNT_W + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [NB-1:0]    ch_d;
  logic [1:0]       mode_s;
  logic             clr_s;

  logic [NCH-1:0]   f_c;
  logic [NCH-1:0]   rise_c;
  logic [NCH-1:0]   c_bits_c;
  logic [1:0]       inc_c;

  logic [NCH-1:0]   f_prev_q;
  logic [NCH-1:0]   x_q;
  logic [NCH-1:0]   y_q;
  logic [NCH-1:0]   pulse_q;
  logic [CNT_W-1:0] cnt_q;
  logic             ovf_q;

  logic [NCH-1:0]   x_nxt_c;
  logic [NCH-1:0]   y_nxt_c;
  logic [CNT_W-1:0] cnt_nxt_c;
  logic             ovf_nxt_c;
  logic [SW-1:0]    sum_c;

  logic             unused_c;

  // Channel inputs: synchronised and debounced
  for (genvar i = 0; i < NB; i++) begin : g_ch
    tt_alvin_sync_deb #(
      .SYNC_STAGES(SYNC_STAGES),
      .DEB_CYCLES (DEB_CYCLES)
    ) u_sd (
      .clk  (clk),
      .rst_n(rst_n),
      .d_in (ui_in[i]),
      .q_out(ch_d[i])
    );
  end

  // Mode select: synchronised only
  for (genvar m = 0; m < 2; m++) begin : g_mode
    tt_alvin_sync_deb #(
      .SYNC_STAGES(SYNC_STAGES),
      .DEB_CYCLES (0)
    ) u_sd (
      .clk  (clk),
      .rst_n(rst_n),
      .d_in (ui_in[UI_MODE_LSB + m]),
      .q_out(mode_s[m])
    );
  end

  // Clear: synchronised only
  tt_alvin_sync_deb #(
    .SYNC_STAGES(SYNC_STAGES),
    .DEB_CYCLES (0)
  ) u_clr (
    .clk  (clk),
    .rst_n(rst_n),
    .d_in (uio_in[UIO_CLR_BIT]),
    .q_out(clr_s)
  );

  // Per-channel function, rising-edge detect and event popcount
  always_comb begin
    f_c      = '0;
    rise_c   = '0;
    c_bits_c = '0;
    inc_c    = '0;
    for (int unsigned c = 0; c < NCH; c++) begin
      f_c[c]      = gate_f(ch_d[CH_BITS*c + BIT_A],
                           ch_d[CH_BITS*c + BIT_B],
                           ch_d[CH_BITS*c + BIT_C]);
      c_bits_c[c] = ch_d[CH_BITS*c + BIT_C];
      rise_c[c]   = f_c[c] & ~f_prev_q[c];
      inc_c       = inc_c + 2'(rise_c[c]);
    end
  end

  // Next state for output registers and the event counter
  always_comb begin
    x_nxt_c   = x_q;
    y_nxt_c   = y_q;
    cnt_nxt_c = cnt_q;
    ovf_nxt_c = ovf_q;
    sum_c     = {1'b0, cnt_q} + SW'(inc_c);

    for (int unsigned c = 0; c < NCH; c++) begin
      case (mode_s)
        MODE_DIRECT: x_nxt_c[c] = f_c[c];
        MODE_STICKY: x_nxt_c[c] = clr_s ? 1'b0 : (x_q[c] | f_c[c]);
        MODE_TOGGLE: x_nxt_c[c] = x_q[c] ^ rise_c[c];
        default:     x_nxt_c[c] = x_q[c];
      endcase
    end

    if (mode_s != MODE_HOLD) begin
      y_nxt_c = ~c_bits_c;
    end

    // Clear wins over any same-cycle event; the sum's top bit flags overflow
    if (clr_s) begin
      cnt_nxt_c = '0;
      ovf_nxt_c = 1'b0;
    end else if (sum_c[CNT_W]) begin
      ovf_nxt_c = 1'b1;
      cnt_nxt_c = CNT_SAT ? CNT_MAX : sum_c[CNT_W-1:0];
    end else begin
      cnt_nxt_c = sum_c[CNT_W-1:0];
    end
  end

  // State registers; f_prev starts at 1 to match f on all-zero debounced inputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      f_prev_q <= '1;
      x_q      <= '0;
      y_q      <= '0;
      pulse_q  <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      f_prev_q <= f_c;
      x_q      <= x_nxt_c;
      y_q      <= y_nxt_c;
      pulse_q  <= rise_c;
      cnt_q    <= cnt_nxt_c;
      ovf_q    <= ovf_nxt_c;
    end
  end

  // Pin mapping of registered state
  always_comb begin
    uo_out = '0;
    for (int unsigned c = 0; c < NCH; c++) begin
      uo_out[2*c]             = x_q[c];
      uo_out[2*c + 1]         = y_q[c];
      uo_out[UO_RISE_LSB + c] = pulse_q[c];
    end
    uo_out[UO_OVF_BIT] = ovf_q;
  end

  assign uio_out = 8'({cnt_q, 1'b0});
  assign uio_oe  = UIO_OE_VAL;

  // Pins with no function in this configuration
  assign unused_c = ^{ena, ui_in, uio_in};

endmodule

// File: tb/tb_tt_um_alvin_asmar_logic_seq.sv
// Scoreboarded bench: two DUTs (saturating and wrapping counter) share stimulus.
module tb_tt_um_alvin_asmar_logic_seq;

  localparam int S    = 2;
  localparam int DEB  = 4;
  localparam int W    = 7;
  localparam int MAXC = (1 << W) - 1;

  localparam logic [2:0] LO = 3'b100;  // C=1, A=B=0 -> f=0
  localparam logic [2:0] HI = 3'b000;  // C=0       -> f=1

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  tt_um_alvin_asmar_logic_seq_if bus_a ();
  tt_um_alvin_asmar_logic_seq_if bus_b ();

  tt_um_alvin_asmar_logic_seq #(.CNT_SAT(1'b1)) dut_a (
    .ui_in  (bus_a.ui_in),
    .uo_out (bus_a.uo_out),
    .uio_in (bus_a.uio_in),
    .uio_out(bus_a.uio_out),
    .uio_oe (bus_a.uio_oe),
    .ena    (bus_a.ena),
    .clk    (clk),
    .rst_n  (rst_n)
  );

  tt_um_alvin_asmar_logic_seq #(.CNT_SAT(1'b0)) dut_b (
    .ui_in  (bus_b.ui_in),
    .uo_out (bus_b.uo_out),
    .uio_in (bus_b.uio_in),
    .uio_out(bus_b.uio_out),
    .uio_oe (bus_b.uio_oe),
    .ena    (bus_b.ena),
    .clk    (clk),
    .rst_n  (rst_n)
  );

  typedef struct packed {
    logic [7:0] uo_a;
    logic [7:0] uo_b;
    logic [7:0] uio_a;
    logic [7:0] uio_b;
  } exp_t;

  exp_t exp_q[$];

  // Reference model state
  logic [7:0] m_pipe[$];   // raw ui samples still inside the synchroniser
  logic       m_clrp[$];
  logic [5:0] m_hist[$];   // most recent DEB synchronised channel samples
  logic [5:0] m_deb;
  logic [1:0] m_fprev, m_x, m_y, m_p;
  int         m_cnt_a, m_cnt_b;
  bit         m_ovf_a, m_ovf_b;

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] ui_of(input logic [1:0] mode, input logic [2:0] ch1,
                                       input logic [2:0] ch0);
    return {mode, ch1, ch0};
  endfunction

  task automatic model_reset();
    m_pipe = {};
    m_clrp = {};
    m_hist = {};
    for (int i = 0; i < S; i++) begin
      m_pipe.push_back(8'h00);
      m_clrp.push_back(1'b0);
    end
    for (int i = 0; i < DEB; i++) m_hist.push_back(6'h00);
    m_deb   = '0;
    m_fprev = 2'b11;
    m_x     = '0;
    m_y     = '0;
    m_p     = '0;
    m_cnt_a = 0;
    m_cnt_b = 0;
    m_ovf_a = 0;
    m_ovf_b = 0;
  endtask

  function automatic void cnt_step(inout int cnt, inout bit ovf, input int inc,
                                   input bit sat, input bit clr);
    if (clr) begin
      cnt = 0;
      ovf = 0;
    end else if (cnt + inc > MAXC) begin
      ovf = 1;
      cnt = sat ? MAXC : (cnt + inc) % (MAXC + 1);
    end else begin
      cnt = cnt + inc;
    end
  endfunction

  // Advance the model by one clock edge given the pins present at that edge
  task automatic model_edge(input logic [7:0] ui, input logic clr);
    logic [7:0] seen;
    logic       seen_clr;
    logic [1:0] mode, f, rise;
    logic [5:0] nd;
    int         inc;
    exp_t       e;

    seen     = m_pipe.pop_front();
    seen_clr = m_clrp.pop_front();
    m_pipe.push_back(ui);
    m_clrp.push_back(clr);
    mode = seen[7:6];

    m_hist.push_back(seen[5:0]);
    if (m_hist.size() > DEB) void'(m_hist.pop_front());

    for (int c = 0; c < 2; c++) begin
      f[c]    = (m_deb[3*c] & m_deb[3*c+1]) | ~m_deb[3*c+2];
      rise[c] = f[c] & ~m_fprev[c];
    end

    // A bit flips once its last DEB synchronised samples all disagree with it
    nd = m_deb;
    for (int b = 0; b < 6; b++) begin
      bit all_diff;
      all_diff = 1;
      foreach (m_hist[j]) if (m_hist[j][b] == m_deb[b]) all_diff = 0;
      if (all_diff) nd[b] = ~m_deb[b];
    end

    for (int c = 0; c < 2; c++) begin
      case (mode)
        2'd0: m_x[c] = f[c];
        2'd1: m_x[c] = seen_clr ? 1'b0 : (m_x[c] | f[c]);
        2'd2: m_x[c] = m_x[c] ^ rise[c];
        default: ;
      endcase
    end
    if (mode != 2'd3) m_y = ~{m_deb[5], m_deb[2]};
    m_p = rise;

    inc = int'(rise[0]) + int'(rise[1]);
    cnt_step(m_cnt_a, m_ovf_a, inc, 1'b1, seen_clr);
    cnt_step(m_cnt_b, m_ovf_b, inc, 1'b0, seen_clr);

    m_fprev = f;
    m_deb   = nd;

    e.uo_a  = {1'b0, m_ovf_a, m_p[1], m_p[0], m_y[1], m_x[1], m_y[0], m_x[0]};
    e.uo_b  = {1'b0, m_ovf_b, m_p[1], m_p[0], m_y[1], m_x[1], m_y[0], m_x[0]};
    e.uio_a = 8'(m_cnt_a << 1);
    e.uio_b = 8'(m_cnt_b << 1);
    exp_q.push_back(e);
  endtask

  // Drive pins for one clock period and let the model see that edge
  task automatic step(input logic [7:0] ui, input logic clr);
    bus_a.ui_in  = ui;
    bus_b.ui_in  = ui;
    bus_a.uio_in = {7'b0, clr};
    bus_b.uio_in = {7'b0, clr};
    @(posedge clk);
    #1;
    model_edge(ui, clr);
  endtask

  task automatic hold(input logic [7:0] ui, input logic clr, input int n);
    repeat (n) step(ui, clr);
  endtask

  task automatic check_reset_pins(input string tag);
    check8({tag, "_uo_a"},  bus_a.uo_out,  8'h00);
    check8({tag, "_uo_b"},  bus_b.uo_out,  8'h00);
    check8({tag, "_uio_a"}, bus_a.uio_out, 8'h00);
    check8({tag, "_uio_b"}, bus_b.uio_out, 8'h00);
    check8({tag, "_oe_a"},  bus_a.uio_oe,  8'hFE);
  endtask

  // Monitor: compare every cycle's DUT outputs against the queued expectation
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check8("sb_uo_a",  bus_a.uo_out,  e.uo_a);
      check8("sb_uo_b",  bus_b.uo_out,  e.uo_b);
      check8("sb_uio_a", bus_a.uio_out, e.uio_a);
      check8("sb_uio_b", bus_b.uio_out, e.uio_b);
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    bus_a.ena = 1'b1;
    bus_b.ena = 1'b1;
    bus_a.ui_in = '0;
    bus_b.ui_in = '0;
    bus_a.uio_in = '0;
    bus_b.uio_in = '0;
    model_reset();

    // Reset and idle
    #2;
    check_reset_pins("rst0");
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_pins("rst1");
    #1 rst_n = 1'b1;
    hold(ui_of(2'd0, HI, HI), 1'b0, 10);

    // Latency: ch0 C=1 drops x0,y0 seven edges after the change
    lat = 0;
    do begin
      step(ui_of(2'd0, HI, LO), 1'b0);
      lat++;
    end while (bus_a.uo_out[1:0] != 2'b00 && lat < 20);
    check_int("latency_fall", lat, 7);
    hold(ui_of(2'd0, HI, LO), 1'b0, 4);
    lat = 0;
    do begin
      step(ui_of(2'd0, HI, 3'b111), 1'b0);
      lat++;
    end while (bus_a.uo_out[0] != 1'b1 && lat < 20);
    check_int("latency_rise", lat, 7);
    hold(ui_of(2'd0, HI, 3'b111), 1'b0, 6);

    // Glitch rejection: 3 cycles ignored, 4 cycles accepted
    hold(ui_of(2'd0, HI, HI), 1'b0, 10);
    hold(ui_of(2'd0, HI, LO), 1'b0, 3);
    hold(ui_of(2'd0, HI, HI), 1'b0, 10);
    hold(ui_of(2'd0, HI, LO), 1'b0, 4);
    hold(ui_of(2'd0, HI, HI), 1'b0, 10);

    // Sticky with clear
    hold(ui_of(2'd1, HI, LO), 1'b0, 8);
    hold(ui_of(2'd1, HI, HI), 1'b0, 8);
    hold(ui_of(2'd1, HI, LO), 1'b0, 10);
    hold(ui_of(2'd1, HI, LO), 1'b1, 4);
    hold(ui_of(2'd1, HI, LO), 1'b0, 6);

    // Toggle, then hold mode with one more rise
    hold(ui_of(2'd2, HI, LO), 1'b0, 6);
    repeat (3) begin
      hold(ui_of(2'd2, HI, HI), 1'b0, 6);
      hold(ui_of(2'd2, HI, LO), 1'b0, 6);
    end
    hold(ui_of(2'd3, HI, LO), 1'b0, 6);
    hold(ui_of(2'd3, HI, HI), 1'b0, 10);

    // Counter limits: clear, then 65 double rises and one single rise
    hold(ui_of(2'd0, LO, LO), 1'b1, 5);
    hold(ui_of(2'd0, LO, LO), 1'b0, 6);
    repeat (65) begin
      hold(ui_of(2'd0, HI, HI), 1'b0, 5);
      hold(ui_of(2'd0, LO, LO), 1'b0, 5);
    end
    hold(ui_of(2'd0, LO, HI), 1'b0, 5);
    hold(ui_of(2'd0, LO, LO), 1'b0, 10);
    check8("sat_count", bus_a.uio_out, 8'hFE);
    check8("sat_ovf", {7'b0, bus_a.uo_out[6]}, 8'h01);
    check8("wrap_count", bus_b.uio_out, 8'h06);
    check8("wrap_ovf", {7'b0, bus_b.uo_out[6]}, 8'h01);
    hold(ui_of(2'd0, LO, LO), 1'b1, 4);
    hold(ui_of(2'd0, LO, LO), 1'b0, 2);
    check8("clr_count", bus_a.uio_out, 8'h00);
    check8("clr_ovf", {7'b0, bus_a.uo_out[6]}, 8'h00);

    // Reset in the middle of a partially accepted change
    hold(ui_of(2'd0, HI, HI), 1'b0, 10);
    hold(ui_of(2'd0, HI, LO), 1'b0, 4);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check_reset_pins("rst_mid");
    exp_q.delete();
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1 rst_n = 1'b1;
    hold(ui_of(2'd0, HI, LO), 1'b0, 3);
    hold(ui_of(2'd0, HI, HI), 1'b0, 10);

    // Randomised segments
    for (int i = 0; i < 250; i++) begin
      logic [7:0] v;
      logic       cl;
      int         n;
      v  = 8'($urandom);
      cl = ($urandom_range(0, 7) == 0);
      n  = $urandom_range(1, 8);
      hold(v, cl, n);
    end

    hold(8'h00, 1'b0, 12);
    @(negedge clk);
    #1;
    check_int("sb_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tt_um_alvin_asmar_logic_seq.md
Name: tt_um_alvin_asmar_logic_seq

Overview:
Parametrised, registered successor to the team's 3-input gate cell. It computes x = (A & B) | ~C and y = ~C per channel from ui_in. Inputs are synchronised and debounced, and x is driven through a selectable output mode (direct, sticky, toggle, hold). A saturating or wrapping counter of x rising events is exposed on the bidirectional pins. It sits at the TinyTapeout top level with the standard tt_um port list.

Parameters:
NCH, 2, channel count, 1 or 2 (pin-limited). Channel c uses ui_in[3c+2:3c] as {C,B,A}.
SYNC_STAGES, 2, synchroniser depth for every used input bit (legal range 2..4).
DEB_CYCLES, 4, consecutive stable cycles required before a synchronised bit is accepted; 0 = debounce bypassed.
CNT_W, 7, event counter width (1..7).
CNT_SAT, 1, 1 = counter saturates at 2^CNT_W-1; 0 = counter wraps modulo 2^CNT_W.

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous, active-low reset
ena  in  1  always 1 when powered; unused
ui_in  in  8  [2:0] ch0 {C,B,A}; [5:3] ch1 {C,B,A}; [7:6] mode
uo_out  out  8  [2c] x_c; [2c+1] y_c; [4+c] rise pulse for ch c; [6] ovf; [7] 0
uio_in  in  8  [0] clr (level-sensitive); [7:1] unused
uio_out  out  8  [CNT_W:1] count; other bits 0
uio_oe  out  8  constant 8'b1111_1110

Behaviour:
- Reset: all flops clear asynchronously on rst_n low. uo_out=0, uio_out=0, mode=DIRECT, debounced bits=0, count=0, ovf=0. f_prev resets to 1; this matches f evaluated on all-zero debounced inputs, so no spurious event occurs after release.
- Input path: each used bit, plus mode[1:0] and clr, passes through SYNC_STAGES flops.
- Debounce: applies to channel bits only; mode and clr are synchronised only. Per bit: if s==d, then cnt<=0. Otherwise, if cnt==DEB_CYCLES-1, then d<=s and cnt<=0; else cnt++. Any reversal before acceptance restarts the count.
- Function: f_c = (A_d & B_d) | ~C_d, combinational from debounced bits. rise_c = f_c & ~f_prev_c. f_prev_c <= f_c every cycle in all modes.
- Latency: a stable ui_in change at edge k appears on uo_out at edge k+SYNC_STAGES+DEB_CYCLES+1 (7 with defaults).
- Output register per channel, selected by mode:
  - DIRECT (00): x_q<=f.
  - STICKY (01): x_q<=x_q|f; clr forces x_q<=0, with clr having priority.
  - TOGGLE (10): x_q<=x_q^rise.
  - HOLD (11): x_q holds.
  - y_q<=~C_d in all modes except HOLD, where y_q holds.
  - A mode change takes effect on the first edge after the synchronised mode changes; x_q keeps its value across the switch.
- Pulses: uo_out[4+c] <= rise_c, a single cycle per event, independent of mode (including HOLD).
- Counter: inc = popcount(rise[NCH-1:0]), 0..2 per cycle.
  - clr has priority: count<=0, ovf<=0.
  - If count+inc > 2^CNT_W-1: ovf<=1 (sticky); CNT_SAT=1 gives count<=max, CNT_SAT=0 gives count<=(count+inc) mod 2^CNT_W.
  - Otherwise count<=count+inc.
  - Compute the sum at CNT_W+1 bits.
- Simultaneous clr with rise: clear wins and the rise is not counted; the pulse output still fires.
- NCH=1: ui_in[5:3] unused; uo_out[3:2] and uo_out[5] tied 0.
- Reset mid-operation: all state, including debounce counters and partially accepted bits, returns to reset values immediately.

Decomposition:
- Package tt_alvin_pkg holds:
  - mode localparams MODE_DIRECT=2'd0, MODE_STICKY=2'd1, MODE_TOGGLE=2'd2, MODE_HOLD=2'd3;
  - pin-index constants for the ui_in fields;
  - the uio_oe constant.
- Sub-module tt_alvin_sync_deb: one bit, parameters SYNC_STAGES and DEB_CYCLES, ports clk, rst_n, d_in, q_out. Instantiated with a generate loop over the 3*NCH channel bits. mode and clr use it with DEB_CYCLES=0.

Test Plan:
1. Reset/idle: hold rst_n low with ui_in=0 -> uo_out=0x00, uio_out=0x00, uio_oe=0xFE. Release -> after 1st edge uo_out=0x0F (x,y=1 for both channels), no pulse, count=0.
2. Latency, defaults: mode 00, set ch0 C=1 with A=B=0 -> uo_out[1:0] goes 11->00 exactly 7 edges later. Then A=B=1 -> uo_out[0]=1 after 7 edges, uo_out[4] high for exactly 1 cycle, uio_out=0x02.
3. Glitch rejection: ch0 C=1 held for only 3 cycles, then back to 0 -> uo_out unchanged, count unchanged. Then hold it for 4 cycles -> change accepted.
4. Sticky/clear: mode 01, pulse ch0 f low->high->low -> x0 stays 1. uio_in[0]=1 -> x0=0 and count=0 three edges later (2 sync + 1), ovf=0.
5. Toggle: mode 10, 3 ch0 rises -> x0 sequence 0->1->0->1, count=3. Switch to mode 11 and apply one more rise -> x0 stays 1, count=4, uo_out[4] pulses.
6. Counter limits: both channels rise in the same cycle -> count +2. CNT_SAT=1, 130 rises -> count=127, ovf=1. CNT_SAT=0, 129 rises -> count=1, ovf=1. clr -> count=0, ovf=0.
